// File: rtl/ncc_window_feeder_if.sv
// Raw pixel stream into the NCC window feeder: 8-bit unsigned pixel with valid/ready handshake.
interface ncc_window_feeder_if;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/ncc_window_feeder.sv
// Feeds the 16x16 NCC PE array: encodes raw pixels to log2 format, buffers them and
// fires one pixel per cycle, then drains the systolic array with zero fires.
module ncc_window_feeder #(
    parameter int WIN_W      = 640,
    parameter int WIN_H      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FLUSH_CYC  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    ncc_window_feeder_if.slave pix,
    input  logic               hold,
    output logic [5:-27]       windowIn,
    output logic               loadWinReg,
    output logic               loadAccSumReg,
    output logic               row_done,
    output logic               busy,
    output logic               done
);
    localparam int TOTAL = WIN_W * WIN_H;
    localparam int ACC_W = $clog2(TOTAL + 1);
    localparam int COL_W = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int ROW_W = (WIN_H > 1) ? $clog2(WIN_H) : 1;
    localparam int FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(TOTAL);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WIN_H - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W:0]   ROOM     = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_cnt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [FL_W-1:0]  flush_cnt;

    logic [32:0]      data_p0;
    logic             vld_p0;
    logic [32:0]      mem_p1 [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CNT_W-1:0] cnt_p1;

    logic in_stream, in_flush, accept;
    logic fire, pop, last_pix, flush_last;

    // Leading-one position is the integer part; the bits below it, left-aligned, form the fraction.
    // p=1 has no bits below its leading one, so it encodes to zero exactly like p=0.
    function automatic logic [32:0] encode_log2(input logic [7:0] p);
        logic [2:0] lead;
        logic [7:0] shifted;
        lead = '0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) lead = 3'(i);
        end
        shifted = p << (3'd7 - lead);
        if (p == 8'd0) return '0;
        return {1'b0, 2'b00, lead, shifted[6:0], 20'd0};
    endfunction

    assign in_stream = (state_q == S_STREAM);
    assign in_flush  = (state_q == S_FLUSH);
    assign pix.pix_ready = in_stream && (acc_cnt < ACC_MAX)
                         && (((CNT_W + 1)'(cnt_p1) + (CNT_W + 1)'(vld_p0)) < ROOM);
    assign accept = pix.pix_valid && pix.pix_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        fire          = 1'b0;
        pop           = 1'b0;
        last_pix      = 1'b0;
        flush_last    = 1'b0;
        windowIn      = '0;
        loadWinReg    = 1'b0;
        loadAccSumReg = 1'b0;
        row_done      = 1'b0;
        busy          = in_stream || in_flush;
        done          = (state_q == S_DONE);

        fire          = !hold && ((in_stream && (cnt_p1 != '0)) || in_flush);
        pop           = fire && in_stream;
        last_pix      = pop && (col == COL_LAST) && (row == ROW_LAST);
        flush_last    = fire && in_flush && (flush_cnt == FL_LAST);
        loadWinReg    = fire;
        loadAccSumReg = fire;
        row_done      = pop && (col == COL_LAST);
        if (pop) windowIn = mem_p1[rd_ptr_p1];

        case (state_q)
            S_IDLE:   if (start)      state_d = S_STREAM;
            S_STREAM: if (last_pix)   state_d = S_FLUSH;
            S_FLUSH:  if (flush_last) state_d = S_DONE;
            S_DONE:                   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt   <= '0;
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
        end else begin
            if (state_q == S_IDLE)  acc_cnt <= '0;
            else if (accept)        acc_cnt <= acc_cnt + ACC_W'(1);

            if (state_q == S_IDLE) begin
                col <= '0;
                row <= '0;
            end else if (pop) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (!in_flush)  flush_cnt <= '0;
            else if (fire)  flush_cnt <= flush_cnt + FL_W'(1);
        end
    end

    // ---- stage p0 (encode register) -> stage p1 (FIFO) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            cnt_p1    <= '0;
        end else begin
            vld_p0 <= accept;
            if (vld_p0) wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
            if (pop)    rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
            case ({vld_p0, pop})
                2'b10:   cnt_p1 <= cnt_p1 + CNT_W'(1);
                2'b01:   cnt_p1 <= cnt_p1 - CNT_W'(1);
                default: cnt_p1 <= cnt_p1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data_p0 <= encode_log2(pix.pix_data);
        if (vld_p0) mem_p1[wr_ptr_p1] <= data_p0;
    end
endmodule

// File: tb/tb_ncc_window_feeder.sv
// Scoreboard bench for ncc_window_feeder on a small 4x2 window with a 3-cycle flush.
module tb_ncc_window_feeder;
    localparam int WIN_W      = 4;
    localparam int WIN_H      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int FLUSH_CYC  = 3;
    localparam int TOTAL      = WIN_W * WIN_H;

    typedef enum {M_IDLE, M_STR, M_FL, M_DONE} phase_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         hold;
    logic [5:-27] window_in;
    logic         load_win, load_acc, row_done, busy, done;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;

    phase_t       ph;
    logic [32:0]  exp_q [$];
    int           acc_run, data_fires, fl_fires, first_acc_cyc, runs_done;
    bit           stage_m, acc_now;
    logic [7:0]   pat [TOTAL];

    ncc_window_feeder_if pix();

    ncc_window_feeder #(
        .WIN_W(WIN_W), .WIN_H(WIN_H), .FIFO_DEPTH(FIFO_DEPTH), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix(pix), .hold(hold),
        .windowIn(window_in), .loadWinReg(load_win), .loadAccSumReg(load_acc),
        .row_done(row_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [32:0] enc_m(input logic [7:0] p);
        logic [32:0] r;
        int msb;
        r = '0;
        msb = -1;
        for (int i = 7; i >= 0; i--) if (p[i] && msb < 0) msb = i;
        if (msb > 0) begin
            r[31:27] = 5'(msb);
            for (int j = 1; j <= msb; j++) r[27-j] = p[msb-j];
        end
        return r;
    endfunction

    task automatic checkw(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        ph = M_IDLE;
        exp_q.delete();
        stage_m = 0;
        acc_run = 0;
        data_fires = 0;
        fl_fires = 0;
    endtask

    task automatic monitor();
        bit          exp_ready, exp_fire, exp_rd;
        int          fifo_m;
        logic [32:0] exp_w;
        acc_now = 0;
        if (rst) return;
        fifo_m    = exp_q.size() - (stage_m ? 1 : 0);
        exp_ready = (ph == M_STR) && (acc_run < TOTAL) && (exp_q.size() < FIFO_DEPTH);
        exp_fire  = !hold && (((ph == M_STR) && (fifo_m > 0)) || (ph == M_FL));
        check1("pix_ready", pix.pix_ready, exp_ready);
        check1("loadWinReg", load_win, exp_fire);
        check1("loadAccSumReg", load_acc, exp_fire);
        check1("busy", busy, (ph == M_STR) || (ph == M_FL));
        check1("done", done, ph == M_DONE);
        exp_w  = '0;
        exp_rd = 0;
        if (exp_fire && ph == M_STR) begin
            exp_w  = exp_q.pop_front();
            exp_rd = (data_fires % WIN_W) == (WIN_W - 1);
            if (data_fires == 0) checkw("first_fire_latency", 33'(cyc - first_acc_cyc), 33'd2);
            data_fires++;
        end
        checkw("windowIn", window_in, exp_w);
        check1("row_done", row_done, exp_rd);
        acc_now = pix.pix_valid && exp_ready;
        if (acc_now) begin
            if (acc_run == 0) first_acc_cyc = cyc;
            exp_q.push_back(enc_m(pix.pix_data));
            acc_run++;
        end
        stage_m = acc_now;
        case (ph)
            M_IDLE: if (start) begin
                ph = M_STR;
                acc_run = 0;
                data_fires = 0;
            end
            M_STR: if (data_fires == TOTAL) begin
                ph = M_FL;
                fl_fires = 0;
            end
            M_FL: if (exp_fire) begin
                fl_fires++;
                if (fl_fires == FLUSH_CYC) ph = M_DONE;
            end
            M_DONE: begin
                ph = M_IDLE;
                runs_done++;
                checkw("drained", 33'(exp_q.size()), 33'd0);
            end
            default: ph = M_IDLE;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        int t;
        t = 0;
        pix.pix_data  = p;
        pix.pix_valid = 1'b1;
        tick();
        while (!acc_now && t < 50) begin
            tick();
            t++;
        end
        check1("send_accept", acc_now, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int r0, t;
        r0 = runs_done;
        t = 0;
        while (runs_done == r0 && t < 100) begin
            tick();
            t++;
        end
        check1("run_complete", runs_done != r0, 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check1({tag, "_pix_ready"}, pix.pix_ready, 1'b0);
        check1({tag, "_loadWinReg"}, load_win, 1'b0);
        check1({tag, "_loadAccSumReg"}, load_acc, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_row_done"}, row_done, 1'b0);
        checkw({tag, "_windowIn"}, window_in, 33'd0);
    endtask

    initial begin
        int idx, t;
        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        pix.pix_valid = 1'b0;
        pix.pix_data = '0;
        runs_done = 0;
        first_acc_cyc = 0;
        model_reset();
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Run 1: encoder corner values, continuous valid, no stalls
        pat = '{8'd0, 8'd1, 8'd2, 8'd200, 8'd255, 8'd5, 8'd128, 8'd64};
        pulse_start();
        for (int i = 0; i < TOTAL; i++) send(pat[i]);
        pix.pix_valid = 1'b0;
        wait_done();
        tick();

        // Run 2: hold for 10 cycles mid-row, then start and hold during flush
        pat = '{8'd3, 8'd17, 8'd99, 8'd254, 8'd1, 8'd0, 8'd31, 8'd160};
        pulse_start();
        idx = 0;
        while (idx < 3) begin
            send(pat[idx]);
            idx++;
        end
        hold = 1'b1;
        repeat (10) begin
            pix.pix_valid = 1'b1;
            pix.pix_data = pat[idx];
            tick();
            if (acc_now) idx++;
        end
        hold = 1'b0;
        while (idx < TOTAL) begin
            send(pat[idx]);
            idx++;
        end
        pix.pix_valid = 1'b0;
        t = 0;
        while (ph != M_FL && t < 100) begin
            tick();
            t++;
        end
        check1("reached_flush", ph == M_FL, 1'b1);
        start = 1'b1;
        hold = 1'b1;
        tick();
        start = 1'b0;
        tick();
        hold = 1'b0;
        wait_done();

        // Run 3: gappy valid, start pulsed while streaming
        pat = '{8'd255, 8'd0, 8'd77, 8'd128, 8'd129, 8'd2, 8'd3, 8'd250};
        pulse_start();
        for (int i = 0; i < TOTAL; i++) begin
            send(pat[i]);
            pix.pix_valid = 1'b0;
            start = (i == 3);
            tick();
            start = 1'b0;
        end
        wait_done();

        // Run 4: asynchronous reset mid-stream discards buffered pixels
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'(40 + 30 * i));
        check1("busy_before_rst", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        pix.pix_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_outputs_zero("after_rst");

        // Run 5: fresh run after reset with random pixels
        pulse_start();
        for (int i = 0; i < TOTAL; i++) send(8'($urandom_range(0, 255)));
        pix.pix_valid = 1'b0;
        wait_done();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
